// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmit channel among NUM_REQ byte producers.
// One byte per grant; waits for the uart to accept (tx_free drop) or time out before re-arbitrating.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned ACCEPT_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  input  logic                 tx_free,
  output logic [7:0]           tx_data,
  output logic                 tx_data_valid,
  output logic                 busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEPT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACCEPT = 2'd1,
    WAIT_FREE   = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [NUM_REQ-1:0] ack_d;
  logic [7:0]         tx_data_d;
  logic               valid_d;
  logic               busy_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   win_next;
  logic [SUM_W-1:0]   scan_idx;
  logic [SUM_W-1:0]   next_sum;

  // First pending requester scanning upward from rr_ptr, modulo NUM_REQ.
  always_comb begin : pick_winner
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    next_sum  = '0;
    win_next  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = SUM_W'(rr_ptr) + SUM_W'(k);
      if (scan_idx >= SUM_W'(NUM_REQ)) begin
        scan_idx = scan_idx - SUM_W'(NUM_REQ);
      end
      if (!win_found && req[scan_idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[PTR_W-1:0];
      end
    end
    next_sum = SUM_W'(win_idx) + SUM_W'(1);
    if (next_sum >= SUM_W'(NUM_REQ)) begin
      next_sum = '0;
    end
    win_next = next_sum[PTR_W-1:0];
  end

  // Next-state and next-output logic; ack/valid default low so they only pulse on a grant.
  always_comb begin : next_logic
    state_d   = state;
    rr_ptr_d  = rr_ptr;
    cnt_d     = cnt;
    ack_d     = '0;
    valid_d   = 1'b0;
    tx_data_d = tx_data;
    case (state)
      IDLE: begin
        if (tx_free && win_found) begin
          tx_data_d      = req_data[{win_idx, 3'b000} +: 8];
          valid_d        = 1'b1;
          ack_d[win_idx] = 1'b1;
          rr_ptr_d       = win_next;
          cnt_d          = '0;
          state_d        = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        if (!tx_free) begin
          state_d = WAIT_FREE;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      WAIT_FREE: begin
        if (tx_free) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      ack           <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      rr_ptr        <= rr_ptr_d;
      cnt           <= cnt_d;
      ack           <= ack_d;
      tx_data       <= tx_data_d;
      tx_data_valid <= valid_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=3, ACCEPT_TIMEOUT=4).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] req_data;
  logic [2:0]  ack;
  logic        tx_free;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(3), .ACCEPT_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .tx_free       (tx_free),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    rst_n    = 1'b0;
    req      = 3'b000;
    req_data = 24'h0;
    tx_free  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ack !== 3'b000 || tx_data_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ack=%b valid=%b data=%h busy=%b, want 000 0 00 0", ack, tx_data_valid, tx_data, busy);
    end
    req = 3'b010; req_data = 24'h005500;
    @(negedge clk);
    req = 3'b000; tx_free = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx_data !== 8'h55) begin
      errors++;
      $display("FAIL reset_pre: busy=%b data=%h, want 1 55", busy, tx_data);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 3'b000 || tx_data_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: ack=%b valid=%b data=%h busy=%b, want 000 0 00 0", ack, tx_data_valid, tx_data, busy);
    end
    req = 3'b111; req_data = 24'h302010; tx_free = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 3'b001 || tx_data !== 8'h10 || tx_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: ack=%b data=%h valid=%b, want 001 10 1", ack, tx_data, tx_data_valid);
    end
    req = 3'b000;
  endtask

  task automatic test_single();
    do_reset();
    req = 3'b010; req_data = 24'h004100;
    @(negedge clk);
    checks++;
    if (tx_data !== 8'h41 || tx_data_valid !== 1'b1 || ack !== 3'b010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: data=%h valid=%b ack=%b busy=%b, want 41 1 010 1", tx_data, tx_data_valid, ack, busy);
    end
    req = 3'b000;
    @(negedge clk);
    checks++;
    if (tx_data_valid !== 1'b0 || ack !== 3'b000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse: valid=%b ack=%b busy=%b, want 0 000 1", tx_data_valid, ack, busy);
    end
    tx_free = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_low: busy=%b, want 1", busy);
    end
    tx_free = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_data !== 8'h41) begin
      errors++;
      $display("FAIL single_done: busy=%b data=%h, want 0 41", busy, tx_data);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_data [3];
    logic [2:0] exp_ack  [3];
    int n_sent;
    int low_cnt;
    exp_data[0] = 8'h41; exp_data[1] = 8'h42; exp_data[2] = 8'h43;
    exp_ack[0]  = 3'b001; exp_ack[1] = 3'b010; exp_ack[2] = 3'b100;
    n_sent = 0;
    low_cnt = 0;
    do_reset();
    req = 3'b111; req_data = 24'h434241;
    for (int cyc = 0; cyc < 300 && n_sent < 6; cyc++) begin
      @(negedge clk);
      if (tx_data_valid === 1'b1) begin
        checks++;
        if (tx_data !== exp_data[n_sent % 3] || ack !== exp_ack[n_sent % 3]) begin
          errors++;
          $display("FAIL rr_send%0d: data=%h ack=%b, want %h %b", n_sent, tx_data, ack, exp_data[n_sent % 3], exp_ack[n_sent % 3]);
        end
        n_sent++;
        tx_free = 1'b0;
        low_cnt = 10;
      end else begin
        checks++;
        if (ack !== 3'b000) begin
          errors++;
          $display("FAIL rr_ack_without_valid: ack=%b, want 000", ack);
        end
        if (low_cnt > 0) begin
          low_cnt--;
          if (low_cnt == 0) tx_free = 1'b1;
        end
      end
    end
    checks++;
    if (n_sent != 6) begin
      errors++;
      $display("FAIL rr_timeout: sent=%0d, want 6", n_sent);
    end
    req = 3'b000; tx_free = 1'b1;
  endtask

  task automatic test_timeout();
    int stamps [3];
    int n;
    n = 0;
    do_reset();
    req = 3'b001; req_data = 24'h000077;
    for (int cyc = 1; cyc < 100 && n < 3; cyc++) begin
      @(negedge clk);
      if (tx_data_valid === 1'b1) begin
        stamps[n] = cyc;
        n++;
        checks++;
        if (ack !== 3'b001 || tx_data !== 8'h77) begin
          errors++;
          $display("FAIL timeout_grant: ack=%b data=%h, want 001 77", ack, tx_data);
        end
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL timeout_lockup: pulses=%0d, want 3", n);
    end else begin
      checks++;
      if (stamps[1] - stamps[0] != 5 || stamps[2] - stamps[1] != 5) begin
        errors++;
        $display("FAIL timeout_spacing: gaps=%0d,%0d, want 5,5", stamps[1] - stamps[0], stamps[2] - stamps[1]);
      end
    end
    req = 3'b000;
  endtask

  task automatic test_blocked();
    bit seen;
    bit got;
    seen = 1'b0;
    got  = 1'b0;
    do_reset();
    tx_free = 1'b0;
    req = 3'b101; req_data = 24'hC200A0;
    repeat (50) begin
      @(negedge clk);
      if (tx_data_valid !== 1'b0 || ack !== 3'b000) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL blocked_quiet: grant seen while tx_free=0, want none");
    end
    tx_free = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 3'b001 || tx_data !== 8'hA0 || tx_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL blocked_first: ack=%b data=%h valid=%b, want 001 a0 1", ack, tx_data, tx_data_valid);
    end
    req = 3'b100; tx_free = 1'b0;
    @(negedge clk);
    tx_free = 1'b1;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (tx_data_valid === 1'b1) begin
        got = 1'b1;
        checks++;
        if (ack !== 3'b100 || tx_data !== 8'hC2) begin
          errors++;
          $display("FAIL blocked_second: ack=%b data=%h, want 100 c2", ack, tx_data);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL blocked_second_timeout: no grant within 20 cycles");
    end
    req = 3'b000;
  endtask

  task automatic test_withdraw();
    bit ack2_seen;
    bit got;
    ack2_seen = 1'b0;
    got = 1'b0;
    do_reset();
    req = 3'b010; req_data = 24'h332211;
    @(negedge clk);
    checks++;
    if (ack !== 3'b010 || tx_data !== 8'h22) begin
      errors++;
      $display("FAIL withdraw_first: ack=%b data=%h, want 010 22", ack, tx_data);
    end
    req = 3'b100; tx_free = 1'b0;
    repeat (2) @(negedge clk);
    if (ack[2] === 1'b1) ack2_seen = 1'b1;
    req = 3'b001;
    @(negedge clk);
    if (ack[2] === 1'b1) ack2_seen = 1'b1;
    tx_free = 1'b1;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (ack[2] === 1'b1) ack2_seen = 1'b1;
      if (tx_data_valid === 1'b1) begin
        got = 1'b1;
        checks++;
        if (ack !== 3'b001 || tx_data !== 8'h11) begin
          errors++;
          $display("FAIL withdraw_next: ack=%b data=%h, want 001 11", ack, tx_data);
        end
      end
    end
    checks++;
    if (!got || ack2_seen) begin
      errors++;
      $display("FAIL withdraw_skip: got=%b ack2_seen=%b, want 1 0", got, ack2_seen);
    end
    req = 3'b000;
  endtask

  initial begin
    rst_n = 1'b0; req = 3'b000; req_data = 24'h0; tx_free = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_blocked();
    test_withdraw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
